// File: rtl/lifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lifo_ctrl_pkg
// Shared types and helpers for the LIFO stack controller.
//   lifo_ctrl_state_t : sequencer states IDLE -> ISSUE -> ACK
//   OP_PUSH / OP_POP  : encoding of the per-requester operation bit
//   cnt_width()       : bit width needed to hold an occupancy of 0..depth
// ---------------------------------------------------------------------------
package lifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } lifo_ctrl_state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    // Occupancy runs 0..depth inclusive, hence depth+1 distinct values.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter producing a one-hot grant.
// The search starts at the requester after i_ptr and wraps at NREQ, so the
// requester served last has the lowest priority next time.
// Ports:
//   i_req  [NREQ-1:0] : request vector
//   i_ptr  [PW-1:0]   : index of the most recently granted requester
//   o_gnt  [NREQ-1:0] : one-hot grant, all zero when no request is pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt
);

    int   w_idx;
    logic w_found;

    // Walk the requesters in priority order starting just after the pointer;
    // the first one found wins.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && i_req[w_idx[PW-1:0]]) begin
                o_gnt[w_idx[PW-1:0]] = 1'b1;
                w_found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lifo_ctrl.sv
// ---------------------------------------------------------------------------
// lifo_ctrl
// Shares one latch-based LIFO stack between NREQ requesters. One push/pop is
// served at a time, chosen round-robin. The controller keeps its own
// occupancy count because the stack's full flag is data-dependent.
// Optional feature macro: LIFO_CTRL_ERRCNT_EN adds a saturating 8-bit count
// of rejected operations on port err_cnt.
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   req/req_psh/req_wdata : per-requester request, op (1=push) and push data
//   ack, err            : one-cycle completion pulse and reject flag
//   rdata               : last successfully popped word
//   count, empty, full  : occupancy and its derived flags
//   stk_psh/stk_pll/stk_din : strobes and data into the stack
//   stk_dout            : stack top, valid while stk_pll is high
//   err_cnt             : rejected-op counter (only with LIFO_CTRL_ERRCNT_EN)
// ---------------------------------------------------------------------------
module lifo_ctrl
    import lifo_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int NREQ  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              req_psh,
    input  logic [NREQ*WIDTH-1:0]        req_wdata,
    output logic [NREQ-1:0]              ack,
    output logic                         err,
    output logic [WIDTH-1:0]             rdata,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         empty,
    output logic                         full,
    output logic                         stk_psh,
    output logic                         stk_pll,
    output logic [WIDTH-1:0]             stk_din,
    input  logic [WIDTH-1:0]             stk_dout
`ifdef LIFO_CTRL_ERRCNT_EN
    ,
    output logic [7:0]                   err_cnt
`endif
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    lifo_ctrl_state_t r_state;
    lifo_ctrl_state_t w_next_state;

    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_ptr;
    logic [NREQ-1:0]  r_gnt;
    logic             r_op;
    logic [WIDTH-1:0] r_wdata;
    logic             r_err;
    logic [WIDTH-1:0] r_rdata;

    logic [NREQ-1:0]  w_gnt;
    logic [PW-1:0]    w_sel_idx;
    logic             w_sel_op;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_push_ok;
    logic             w_pop_ok;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    // Turn the one-hot grant into an index and pick that requester's op/data.
    always_comb begin
        w_sel_idx  = '0;
        w_sel_op   = OP_POP;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_idx  = PW'(i);
                w_sel_op   = req_psh[i];
                w_sel_data = req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // Legality is judged against our own count, never the stack's flag.
    assign w_push_ok = (r_op == OP_PUSH) && (r_count != CW'(DEPTH));
    assign w_pop_ok  = (r_op == OP_POP)  && (r_count != '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one op takes exactly three cycles.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (|req) w_next_state = ISSUE;
            ISSUE:   w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from state only, so an async reset clears them at once.
    always_comb begin
        ack     = '0;
        err     = 1'b0;
        stk_psh = 1'b0;
        stk_pll = 1'b0;
        stk_din = '0;
        case (r_state)
            ISSUE: begin
                stk_psh = w_push_ok;
                stk_pll = w_pop_ok;
                if (w_push_ok) begin
                    stk_din = r_wdata;
                end
            end
            ACK: begin
                ack = r_gnt;
                err = r_err;
            end
            default: ;
        endcase
    end

    // Grant capture in IDLE, occupancy/pop-data update in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_ptr   <= PW'(NREQ - 1);
            r_gnt   <= '0;
            r_op    <= OP_POP;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt   <= w_gnt;
                        r_op    <= w_sel_op;
                        r_wdata <= w_sel_data;
                        r_ptr   <= w_sel_idx;
                    end
                end
                ISSUE: begin
                    r_err <= !(w_push_ok || w_pop_ok);
                    if (w_push_ok) begin
                        r_count <= r_count + CW'(1);
                    end else if (w_pop_ok) begin
                        r_count <= r_count - CW'(1);
                        r_rdata <= stk_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata = r_rdata;
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));

`ifdef LIFO_CTRL_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Count every rejected op as it is acknowledged, sticking at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if ((r_state == ACK) && r_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    // Rejected ops are reported only through err; no counter is built.
`endif

endmodule

// File: tb/tb_lifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lifo_ctrl
// Self-checking bench for lifo_ctrl (WIDTH=8, DEPTH=4, NREQ=2) driving a
// behavioural model of the shared stack. Expected completions are queued when
// a request is driven and compared when ack pulses.
// ---------------------------------------------------------------------------
module tb_lifo_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int NREQ  = 2;

   typedef struct {
      logic [NREQ-1:0]  gnt;
      logic             err;
      logic [WIDTH-1:0] rdata;
      logic [2:0]       count;
   } expT;

   logic                   clk;
   logic                   rst;
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        reqPsh;
   logic [NREQ*WIDTH-1:0]  reqWdata;
   logic [NREQ-1:0]        ack;
   logic                   err;
   logic [WIDTH-1:0]       rdata;
   logic [2:0]             count;
   logic                   empty;
   logic                   full;
   logic                   stkPsh;
   logic                   stkPll;
   logic [WIDTH-1:0]       stkDin;
   logic [WIDTH-1:0]       stkDout;
`ifdef LIFO_CTRL_ERRCNT_EN
   logic [7:0]             errCnt;
`endif

   int testCount = 0;
   int failCount = 0;

   expT              expQ[$];
   logic [WIDTH-1:0] modelStk[$];
   logic [WIDTH-1:0] modelRdata;
   expT              monE;

   logic [WIDTH-1:0] stkMem[DEPTH];
   logic [2:0]       stkSp;

   lifo_ctrl #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .NREQ  (NREQ)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_psh   (reqPsh),
      .req_wdata (reqWdata),
      .ack       (ack),
      .err       (err),
      .rdata     (rdata),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .stk_psh   (stkPsh),
      .stk_pll   (stkPll),
      .stk_din   (stkDin),
      .stk_dout  (stkDout)
`ifdef LIFO_CTRL_ERRCNT_EN
      ,
      .err_cnt   (errCnt)
`endif
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the shared stack, cleared by the same reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stkSp <= 3'd0;
      end else if (stkPsh && (stkSp < 3'(DEPTH))) begin
         stkMem[stkSp[1:0]] <= stkDin;
         stkSp              <= stkSp + 3'd1;
      end else if (stkPll && (stkSp != 3'd0)) begin
         stkSp <= stkSp - 3'd1;
      end
   end

   assign stkDout = (stkPll && (stkSp != 3'd0)) ? stkMem[2'(stkSp - 3'd1)] : '0;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the reference model for one op and queue its expected completion.
   task automatic predict(input int port, input logic psh, input logic [WIDTH-1:0] data,
                          output logic expPsh, output logic expPll);
      expT e;
      e.gnt       = '0;
      e.gnt[port] = 1'b1;
      expPsh      = 1'b0;
      expPll      = 1'b0;
      if (psh) begin
         if (modelStk.size() < DEPTH) begin
            modelStk.push_back(data);
            expPsh = 1'b1;
            e.err  = 1'b0;
         end else begin
            e.err = 1'b1;
         end
      end else begin
         if (modelStk.size() > 0) begin
            modelRdata = modelStk.pop_back();
            expPll     = 1'b1;
            e.err      = 1'b0;
         end else begin
            e.err = 1'b1;
         end
      end
      e.rdata = modelRdata;
      e.count = 3'(modelStk.size());
      expQ.push_back(e);
   endtask

   // Reset the DUT, the stack and the reference model together.
   task automatic resetDut();
      rst      = 1'b1;
      req      = '0;
      reqPsh   = '0;
      reqWdata = '0;
      modelStk.delete();
      expQ.delete();
      modelRdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // One request from a single requester, with strobe and latency checks.
   task automatic applyStimulus(input int port, input logic psh, input logic [WIDTH-1:0] data);
      logic expPsh;
      logic expPll;
      int   waits;
      predict(port, psh, data, expPsh, expPll);
      reqPsh[port]                 = psh;
      reqWdata[port*WIDTH +: WIDTH] = data;
      req[port]                    = 1'b1;
      @(negedge clk);
      checkOutput("stkPsh", 32'(stkPsh), 32'(expPsh));
      checkOutput("stkPll", 32'(stkPll), 32'(expPll));
      if (expPsh) begin
         checkOutput("stkDin", 32'(stkDin), 32'(data));
      end
      waits = 0;
      while ((ack == '0) && (waits < 4)) begin
         @(negedge clk);
         waits++;
      end
      checkOutput("ackLatency", 32'(waits), 32'd1);
      req[port] = 1'b0;
      @(negedge clk);
   endtask

   // Scoreboard: every ack is matched against the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("strobeExcl", 32'(stkPsh & stkPll), 32'd0);
         if (ack != '0) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedAck", 32'(ack), 32'd0);
            end else begin
               monE = expQ.pop_front();
               checkOutput("ackGnt", 32'(ack), 32'(monE.gnt));
               checkOutput("ackErr", 32'(err), 32'(monE.err));
               checkOutput("ackRdata", 32'(rdata), 32'(monE.rdata));
               checkOutput("ackCount", 32'(count), 32'(monE.count));
               checkOutput("ackFull", 32'(full), 32'(monE.count == 3'(DEPTH)));
               checkOutput("ackEmpty", 32'(empty), 32'(monE.count == 3'd0));
            end
         end
      end
   end

   // Hard stop in case something wedges the stimulus thread.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic dummyPsh;
      logic dummyPll;
      int   acks;
      int   guard;

      // Reset values.
      resetDut();
      checkOutput("rstAck", 32'(ack), 32'd0);
      checkOutput("rstErr", 32'(err), 32'd0);
      checkOutput("rstRdata", 32'(rdata), 32'd0);
      checkOutput("rstCount", 32'(count), 32'd0);
      checkOutput("rstEmpty", 32'(empty), 32'd1);
      checkOutput("rstFull", 32'(full), 32'd0);
      checkOutput("rstStkPsh", 32'(stkPsh), 32'd0);
      checkOutput("rstStkPll", 32'(stkPll), 32'd0);
      checkOutput("rstStkDin", 32'(stkDin), 32'd0);

      // Step 1: single push, then drain it again so step 2 starts empty.
      applyStimulus(0, 1'b1, 8'h11);
      checkOutput("step1Count", 32'(count), 32'd1);
      applyStimulus(0, 1'b0, 8'h00);

      // Step 2: fill to DEPTH, then one push too many.
      applyStimulus(0, 1'b1, 8'hA1);
      applyStimulus(1, 1'b1, 8'hA2);
      applyStimulus(0, 1'b1, 8'hA3);
      applyStimulus(1, 1'b1, 8'hA4);
      applyStimulus(0, 1'b1, 8'hA5);
      checkOutput("step2Full", 32'(full), 32'd1);

      // Step 3: pop everything back in reverse order, then underflow.
      applyStimulus(1, 1'b0, 8'h00);
      applyStimulus(0, 1'b0, 8'h00);
      applyStimulus(1, 1'b0, 8'h00);
      applyStimulus(0, 1'b0, 8'h00);
      checkOutput("step3Empty", 32'(empty), 32'd1);
      applyStimulus(1, 1'b0, 8'h00);
      checkOutput("step3RdataHeld", 32'(rdata), 32'hA1);
`ifdef LIFO_CTRL_ERRCNT_EN
      checkOutput("step3ErrCnt", 32'(errCnt), 32'd2);
`endif

      // Step 4: both requesters held high, req0 pushing and req1 popping.
      resetDut();
      for (int k = 0; k < 6; k++) begin
         predict(k % 2, (k % 2) == 0, 8'(8'h40 + k), dummyPsh, dummyPll);
      end
      reqPsh                = 2'b01;
      reqWdata[0 +: WIDTH]  = 8'h40;
      req                   = 2'b11;
      acks  = 0;
      guard = 0;
      while ((acks < 6) && (guard < 40)) begin
         @(negedge clk);
         guard++;
         if (ack != '0) begin
            acks++;
            reqWdata[0 +: WIDTH] = 8'(8'h40 + acks);
            if (acks == 6) begin
               req = '0;
            end
         end
      end
      req = '0;
      checkOutput("step4Acks", 32'(acks), 32'd6);
      repeat (3) @(negedge clk);

      // Step 5: a pushed zero still counts as an entry.
      resetDut();
      applyStimulus(0, 1'b1, 8'h01);
      applyStimulus(0, 1'b1, 8'h02);
      applyStimulus(0, 1'b1, 8'h03);
      applyStimulus(1, 1'b1, 8'h00);
      checkOutput("step5Full", 32'(full), 32'd1);
      applyStimulus(0, 1'b1, 8'h77);
      checkOutput("step5Count", 32'(count), 32'd4);

      // Step 6: reset lands in the ISSUE cycle of a push.
      resetDut();
      reqPsh[0]            = 1'b1;
      reqWdata[0 +: WIDTH] = 8'h33;
      req[0]               = 1'b1;
      @(negedge clk);
      checkOutput("step6Issue", 32'(stkPsh), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("step6Ack", 32'(ack), 32'd0);
      checkOutput("step6StkPsh", 32'(stkPsh), 32'd0);
      checkOutput("step6StkDin", 32'(stkDin), 32'd0);
      checkOutput("step6Count", 32'(count), 32'd0);
      checkOutput("step6Empty", 32'(empty), 32'd1);
      req = '0;
      @(negedge clk);
      checkOutput("step6NoAck", 32'(ack), 32'd0);
      rst = 1'b0;
      @(negedge clk);
`ifdef LIFO_CTRL_ERRCNT_EN
      checkOutput("step6ErrCnt", 32'(errCnt), 32'd0);
`endif
      applyStimulus(1, 1'b0, 8'h00);
      checkOutput("step6PopErrRdata", 32'(rdata), 32'd0);

      checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
